// File: rtl/gray_pkg.sv
// Shared Gray-code helpers used by the Gray encoder and decoder blocks.
// Functions operate on a fixed maximum-width word; narrower codes are
// zero-extended by the caller, which leaves the results unchanged.
package gray_pkg;

    localparam int GRAY_WIDTH_DEF = 4;
    localparam int GRAY_MAX_W     = 32;
    localparam int GRAY_CNT_W     = 6;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;
    typedef logic [GRAY_CNT_W-1:0] gray_cnt_t;

    // Prefix XOR from the MSB down: each bit becomes the XOR of itself and all higher bits.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gray_cnt_t popcount(input gray_word_t w);
        gray_cnt_t cnt;
        cnt = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            cnt = cnt + {{(GRAY_CNT_W-1){1'b0}}, w[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Pure combinational Gray-to-binary conversion. Bit i of the result is the
// XOR of all Gray bits from i upward, the closed form of the MSB-first chain.
module gray2bin_comb
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_to_binary_decoder.sv
// Streaming Gray-to-binary decoder with single-bit-step checking.
// One registered output slot behind a valid/ready handshake; each accepted
// code is decoded and compared with the previously accepted code.
module gray_to_binary_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH     = GRAY_WIDTH_DEF,  // 2..GRAY_MAX_W
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     gray_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 step_err,
    output logic                 step_dir,
    output logic                 first,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam gray_cnt_t        ONE_CNT = GRAY_CNT_W'(1);

    // Counter holds at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + ERR_CNT_W'(1);
    endfunction

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     bin_q,       bin_d;
    logic                 step_err_q,  step_err_d;
    logic                 step_dir_q,  step_dir_d;
    logic                 first_q,     first_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic                 prev_valid_q, prev_valid_d;
    logic [WIDTH-1:0]     prev_gray_q,  prev_gray_d;
    logic [WIDTH-1:0]     prev_bin_q,   prev_bin_d;

    logic                 accept;
    logic [WIDTH-1:0]     bin_new;
    gray_cnt_t            diff_bits;

    gray2bin_comb #(
        .WIDTH (WIDTH)
    ) u_gray2bin (
        .gray_i (gray_in),
        .bin_o  (bin_new)
    );

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign diff_bits = popcount(GRAY_MAX_W'(gray_in ^ prev_gray_q));

    // Next-state: load a new sample on accept, otherwise retire a consumed output.
    always_comb begin
        out_valid_d  = out_valid_q;
        bin_d        = bin_q;
        step_err_d   = step_err_q;
        step_dir_d   = step_dir_q;
        first_d      = first_q;
        err_cnt_d    = err_cnt_q;
        prev_valid_d = prev_valid_q;
        prev_gray_d  = prev_gray_q;
        prev_bin_d   = prev_bin_q;

        if (accept) begin
            out_valid_d  = 1'b1;
            bin_d        = bin_new;
            first_d      = !prev_valid_q;
            step_err_d   = prev_valid_q && (diff_bits != ONE_CNT);
            // Wrap-around (e.g. max -> 0) is covered by the modular increment.
            step_dir_d   = prev_valid_q && (diff_bits == ONE_CNT) &&
                           (bin_new == prev_bin_q + ONE_W);
            if (prev_valid_q && (diff_bits != ONE_CNT)) begin
                err_cnt_d = sat_inc(err_cnt_q);
            end
            // Resynchronise to the latest code even when it was an error.
            prev_valid_d = 1'b1;
            prev_gray_d  = gray_in;
            prev_bin_d   = bin_new;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // State register with synchronous reset of the whole slot and history.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            bin_q        <= '0;
            step_err_q   <= 1'b0;
            step_dir_q   <= 1'b0;
            first_q      <= 1'b0;
            err_cnt_q    <= '0;
            prev_valid_q <= 1'b0;
            prev_gray_q  <= '0;
            prev_bin_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            bin_q        <= bin_d;
            step_err_q   <= step_err_d;
            step_dir_q   <= step_dir_d;
            first_q      <= first_d;
            err_cnt_q    <= err_cnt_d;
            prev_valid_q <= prev_valid_d;
            prev_gray_q  <= prev_gray_d;
            prev_bin_q   <= prev_bin_d;
        end
    end

    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;
    assign step_err  = step_err_q;
    assign step_dir  = step_dir_q;
    assign first     = first_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_to_binary_decoder.sv
// Bench for gray_to_binary_decoder: directed scenarios followed by random
// traffic, all compared against a table-driven model of the stream rules.
module tb_gray_to_binary_decoder;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] gray_in;

    logic         in_ready,  out_valid,  step_err,  step_dir,  first;
    logic [W-1:0] bin_out;
    logic [7:0]   err_cnt;

    logic         in_ready_s, out_valid_s, step_err_s, step_dir_s, first_s;
    logic [W-1:0] bin_out_s;
    logic [1:0]   err_cnt_s;

    gray_to_binary_decoder #(.WIDTH(W), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .gray_in(gray_in), .out_valid(out_valid), .out_ready(out_ready),
        .bin_out(bin_out), .step_err(step_err), .step_dir(step_dir),
        .first(first), .err_cnt(err_cnt)
    );

    gray_to_binary_decoder #(.WIDTH(W), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .gray_in(gray_in), .out_valid(out_valid_s), .out_ready(out_ready),
        .bin_out(bin_out_s), .step_err(step_err_s), .step_dir(step_dir_s),
        .first(first_s), .err_cnt(err_cnt_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_pv;
    int m_pg, m_pb;
    bit m_ov, m_err, m_dir, m_first;
    int m_bin, m_cnt, m_cnt_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Decode by searching the Gray sequence for the code.
    function automatic int g2b(input int g);
        for (int v = 0; v < N; v++) begin
            if ((v ^ (v >> 1)) == g) return v;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pv = 0; m_pg = 0; m_pb = 0;
        m_ov = 0; m_err = 0; m_dir = 0; m_first = 0;
        m_bin = 0; m_cnt = 0; m_cnt_s = 0;
    endtask

    task automatic model_edge(input bit v, input int g, input bit ordy);
        int b, d;
        if (v && (!m_ov || ordy)) begin
            b = g2b(g);
            if (!m_pv) begin
                m_first = 1; m_err = 0; m_dir = 0;
            end else begin
                d = $countones(g ^ m_pg);
                m_first = 0;
                m_err   = (d != 1);
                m_dir   = (d == 1) && (((b - m_pb) % N + N) % N == 1);
                if (m_err) begin
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt_s < 3) m_cnt_s++;
                end
            end
            m_pv = 1; m_pg = g; m_pb = b;
            m_ov = 1; m_bin = b;
        end else if (ordy) begin
            m_ov = 0;
        end
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".out_valid"}, out_valid, m_ov);
        chk({ctx, ".err_cnt"}, err_cnt, m_cnt);
        chk({ctx, ".err_cnt_sat"}, err_cnt_s, m_cnt_s);
        if (m_ov) begin
            chk({ctx, ".bin_out"}, bin_out, m_bin);
            chk({ctx, ".first"}, first, m_first);
            chk({ctx, ".step_err"}, step_err, m_err);
            if (!m_err) chk({ctx, ".step_dir"}, step_dir, m_dir);
        end
    endtask

    task automatic step(input string ctx, input bit v, input int g, input bit ordy);
        rst       = 1'b0;
        in_valid  = v;
        gray_in   = v ? g[W-1:0] : W'($urandom);
        out_ready = ordy;
        #1;
        chk({ctx, ".in_ready"}, in_ready, (!m_ov || ordy));
        @(posedge clk);
        model_edge(v, v ? g : 0, ordy);
        #1;
        check_outputs(ctx);
    endtask

    task automatic do_reset(input string ctx);
        rst       = 1'b1;
        in_valid  = 1'b1;
        gray_in   = W'($urandom);
        out_ready = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        chk({ctx, ".rst_out_valid"}, out_valid, 0);
        chk({ctx, ".rst_bin_out"}, bin_out, 0);
        chk({ctx, ".rst_step_err"}, step_err, 0);
        chk({ctx, ".rst_step_dir"}, step_dir, 0);
        chk({ctx, ".rst_first"}, first, 0);
        chk({ctx, ".rst_err_cnt"}, err_cnt, 0);
        chk({ctx, ".rst_err_cnt_sat"}, err_cnt_s, 0);
        rst = 1'b0;
    endtask

    initial begin
        int cur;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; gray_in = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Basic counting sequence 4, 5, 6
        do_reset("init");
        step("seq0", 1, 4'b0110, 1);
        chk("seq0.first_exact", first, 1);
        chk("seq0.bin_exact", bin_out, 4);
        step("seq1", 1, 4'b0111, 1);
        chk("seq1.dir_exact", step_dir, 1);
        step("seq2", 1, 4'b0101, 1);
        chk("seq2.bin_exact", bin_out, 6);
        chk("seq2.err_exact", err_cnt, 0);

        // Wrap-around both ways
        do_reset("wrap");
        step("wrap_up0", 1, 4'b1000, 1);
        step("wrap_up1", 1, 4'b0000, 1);
        chk("wrap_up.dir_exact", step_dir, 1);
        chk("wrap_up.bin_exact", bin_out, 0);
        step("wrap_dn", 1, 4'b1000, 1);
        chk("wrap_dn.dir_exact", step_dir, 0);
        chk("wrap_dn.err_exact", step_err, 0);

        // Multi-bit change and repeated code
        do_reset("err");
        step("err0", 1, 4'b0000, 1);
        step("err1", 1, 4'b0011, 1);
        chk("err1.cnt_exact", err_cnt, 1);
        step("err2", 1, 4'b0011, 1);
        chk("err2.cnt_exact", err_cnt, 2);
        chk("err2.flag_exact", step_err, 1);

        // Saturation: narrow counter holds at 3 after 5 errors
        for (int i = 0; i < 3; i++) step("sat", 1, 4'b0011, 1);
        chk("sat.narrow_exact", err_cnt_s, 3);
        chk("sat.wide_exact", err_cnt, 5);

        // Backpressure: one accept then stalled for 3 cycles
        do_reset("bp");
        step("bp0", 1, 4'b0001, 0);
        step("bp1", 1, 4'b0011, 0);
        chk("bp1.in_ready_low", in_ready, 0);
        step("bp2", 1, 4'b0011, 0);
        chk("bp2.bin_hold", bin_out, 1);
        step("bp3", 1, 4'b0011, 1);
        chk("bp3.bin_next", bin_out, 2);
        step("bp4", 1, 4'b0010, 1);
        chk("bp4.bin_next", bin_out, 3);
        step("bp5", 0, 0, 1);
        chk("bp5.drain", out_valid, 0);

        // Reset while an output is pending
        step("mid0", 1, 4'b0100, 1);
        step("mid1", 1, 4'b0000, 0);
        chk("mid1.err_nonzero", err_cnt, 1);
        do_reset("mid");
        step("mid2", 1, 4'b1111, 1);
        chk("mid2.first_exact", first, 1);
        chk("mid2.noerr", err_cnt, 0);

        // Random traffic: mostly legal single-bit steps, some jumps
        cur = 0;
        for (int i = 0; i < 400; i++) begin
            bit v, r;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 8) cur = cur ^ (1 << $urandom_range(0, W - 1));
            else cur = $urandom_range(0, N - 1);
            step("rnd", v, cur, r);
            if (i == 200) do_reset("rnd_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_to_binary_decoder.md
Name: gray_to_binary_decoder

Overview:
- Streaming Gray-to-binary decoder. Inverse of the team's binary-to-Gray encoder.
- Accepts one WIDTH-bit Gray code per valid/ready handshake and returns the registered binary value.
- Checks each accepted code against the previous one. Legal Gray streams change exactly one bit per step; any other change is flagged, with a saturating error count.
- Used on the receive side of Gray-coded counters and pointers, e.g. position encoders and async FIFO pointers after synchronisation.

Parameters:
- WIDTH, 4, code width in bits (≥2).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  gray_in is valid this cycle.
- in_ready  output  1  block can accept gray_in this cycle.
- gray_in  input  WIDTH  Gray-coded input.
- out_valid  output  1  bin_out and its flags are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- bin_out  output  WIDTH  decoded binary value.
- step_err  output  1  this sample differs from the previous accepted code in ≠1 bit (0 or ≥2 bits).
- step_dir  output  1  1 = step was +1 mod 2^WIDTH; 0 = −1 mod 2^WIDTH. Valid only when step_err=0 and first=0.
- first  output  1  first sample after reset; no step check applied.
- err_cnt  output  ERR_CNT_W  count of accepted samples with step_err=1; saturates at all-ones.

Behaviour:
- Reset (synchronous, active-high, clk rising edge): out_valid=0, bin_out=0, step_err=0, step_dir=0, first=0, err_cnt=0, prev_valid=0, prev_gray=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - An input is accepted when in_valid && in_ready.
  - Output holds stable while out_valid && !out_ready.
  - out_valid drops the cycle after a transfer with no new accept.
- Latency: 1 cycle, accept at edge N → out_valid=1 after edge N. Full throughput (1 sample/cycle) when out_ready=1.
- Decode: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i=WIDTH-2..0. Combinational from gray_in, registered on accept.
- Step check on accept, using d = popcount(gray_in ^ prev_gray):
  - If prev_valid=0: first=1, step_err=0, step_dir=0.
  - Else: first=0, step_err=(d≠1).
  - When d==1: step_dir=1 iff new_bin == prev_bin+1 mod 2^WIDTH.
  - Wrap-around is a legal single step: 1000→0000 (WIDTH=4) gives step_dir=1; 0000→1000 gives step_dir=0.
- prev_gray, prev_bin and prev_valid update on every accept, including erroneous ones. The stream resynchronises to the latest code.
- err_cnt increments by 1 on each accept with step_err=1 and holds at 2^ERR_CNT_W−1.
- Simultaneous output transfer and new accept: output register reloads in the same edge, with no bubble.
- Reset mid-stream: any pending output is dropped. The next accepted sample is treated as first (no error counted).
- No X propagation: gray_in is ignored when not accepted.

Decomposition:
- Shared package (gray_pkg):
  - WIDTH default.
  - gray2bin function.
  - bin2gray function, shared with the existing encoder.
  - popcount function.
- One natural sub-module: gray2bin_comb, the pure combinational XOR chain. Keep the handshake/check logic in the top.

Test Plan:
- Reset then accept 0110, 0111, 0101 with out_ready=1 → bin_out 4, 5, 6.
  - First sample: first=1.
  - Next two: step_err=0, step_dir=1, err_cnt=0.
- Wrap: accept 1000 then 0000 → bin_out 15 then 0, step_err=0, step_dir=1. Reverse order gives step_dir=0.
- Error: accept 0000 then 0011 (bin 2, 2-bit change) → step_err=1, err_cnt=1. Then repeat 0011 → step_err=1 (d=0), err_cnt=2.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 after the first accept, and bin_out stays stable. Raise out_ready → one transfer per cycle with no loss or duplication.
- Saturation: ERR_CNT_W=2, 5 erroneous steps → err_cnt=3 held.
- Reset mid-stream: assert rst while out_valid=1 → out_valid=0 and err_cnt=0 next cycle. Next sample after reset → first=1, no error.
